// File: rtl/interrupt_sequencer.sv
// Interrupt / RTI stack sequencer: pushes PC and CCR on interrupt entry, pops them on RTI.
// Optional pending-interrupt latch is enabled with the INT_PENDING_LATCH_EN macro.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt,
  input  logic        rti,
  input  logic        load_use,
  input  logic [31:0] pc,
  input  logic [2:0]  ccr,
  output logic        stack_sig,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        pop_pc1,
  output logic        pop_pc2,
  output logic        pop_ccr,
  output logic        flush,
  output logic        busy,
  output logic        fetch_pc_enable,
  output logic [1:0]  mem_data_sel,
  output logic [1:0]  pc_sel,
  output logic [15:0] save_data
);

  typedef enum logic [3:0] {
    IDLE,
    INT_PUSH_PCH,
    INT_PUSH_PCL,
    INT_PUSH_CCR,
    INT_VECTOR,
    RTI_POP_CCR,
    RTI_POP_PCL,
    RTI_POP_PCH,
    RTI_RESUME
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [2:0]  saved_ccr_q, saved_ccr_d;
  logic        pending_now;
  logic        int_req;
  logic        int_take;

  assign int_req  = interrupt | pending_now;
  assign int_take = (state_q == IDLE) && int_req && !rti && !load_use;

`ifdef INT_PENDING_LATCH_EN
  logic pending_q, pending_d;

  // Any request not taken this cycle is remembered once; taking an entry consumes it.
  always_comb begin
    pending_d = (pending_q | interrupt) & ~int_take;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end

  assign pending_now = pending_q;
`else
  assign pending_now = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    saved_pc_d  = saved_pc_q;
    saved_ccr_d = saved_ccr_q;
    if (!load_use) begin
      unique case (state_q)
        IDLE: begin
          if (rti) begin
            state_d = RTI_POP_CCR;
          end else if (int_req) begin
            state_d     = INT_PUSH_PCH;
            saved_pc_d  = pc;
            saved_ccr_d = ccr;
          end
        end
        INT_PUSH_PCH: state_d = INT_PUSH_PCL;
        INT_PUSH_PCL: state_d = INT_PUSH_CCR;
        INT_PUSH_CCR: state_d = INT_VECTOR;
        INT_VECTOR:   state_d = IDLE;
        RTI_POP_CCR:  state_d = RTI_POP_PCL;
        RTI_POP_PCL:  state_d = RTI_POP_PCH;
        RTI_POP_PCH:  state_d = RTI_RESUME;
        RTI_RESUME:   state_d = IDLE;
        default:      state_d = IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous, sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= IDLE;
      saved_pc_q  <= 32'h0;
      saved_ccr_q <= 3'b0;
    end else begin
      state_q     <= state_d;
      saved_pc_q  <= saved_pc_d;
      saved_ccr_q <= saved_ccr_d;
    end
  end

  always_comb begin
    stack_sig       = 1'b0;
    mem_wr          = 1'b0;
    mem_rd          = 1'b0;
    pop_pc1         = 1'b0;
    pop_pc2         = 1'b0;
    pop_ccr         = 1'b0;
    flush           = 1'b0;
    busy            = 1'b0;
    fetch_pc_enable = 1'b1;
    mem_data_sel    = 2'b00;
    pc_sel          = 2'b00;

    if (state_q != IDLE) begin
      flush           = 1'b1;
      busy            = 1'b1;
      fetch_pc_enable = 1'b0;
    end

    unique case (state_q)
      INT_PUSH_PCH: begin stack_sig = 1'b1; mem_wr = 1'b1; mem_data_sel = 2'b01; end
      INT_PUSH_PCL: begin stack_sig = 1'b1; mem_wr = 1'b1; mem_data_sel = 2'b10; end
      INT_PUSH_CCR: begin stack_sig = 1'b1; mem_wr = 1'b1; mem_data_sel = 2'b11; end
      INT_VECTOR:   begin mem_rd = 1'b1; pc_sel = 2'b10; end
      RTI_POP_CCR:  begin stack_sig = 1'b1; mem_rd = 1'b1; pop_ccr = 1'b1; end
      RTI_POP_PCL:  begin stack_sig = 1'b1; mem_rd = 1'b1; pop_pc2 = 1'b1; end
      RTI_POP_PCH:  begin stack_sig = 1'b1; mem_rd = 1'b1; pop_pc1 = 1'b1; end
      RTI_RESUME:   pc_sel = 2'b01;
      default: ;
    endcase

    // A stall freezes the sequence: no memory side effects or redirect while held.
    if (load_use && (state_q != IDLE)) begin
      mem_wr  = 1'b0;
      mem_rd  = 1'b0;
      pop_pc1 = 1'b0;
      pop_pc2 = 1'b0;
      pop_ccr = 1'b0;
      pc_sel  = 2'b00;
    end
  end

  always_comb begin
    unique case (mem_data_sel)
      2'b01:   save_data = saved_pc_q[31:16];
      2'b10:   save_data = saved_pc_q[15:0];
      2'b11:   save_data = {13'b0, saved_ccr_q};
      default: save_data = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus random traffic
// compared against a sequence-level reference model (default build, requests not taken are dropped).
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, interrupt, rti, load_use;
  logic [31:0] pc;
  logic [2:0]  ccr;
  logic        stack_sig, mem_wr, mem_rd, pop_pc1, pop_pc2, pop_ccr;
  logic        flush, busy, fetch_pc_enable;
  logic [1:0]  mem_data_sel, pc_sel;
  logic [15:0] save_data;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .rti(rti), .load_use(load_use),
    .pc(pc), .ccr(ccr),
    .stack_sig(stack_sig), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .pop_pc1(pop_pc1), .pop_pc2(pop_pc2), .pop_ccr(pop_ccr),
    .flush(flush), .busy(busy), .fetch_pc_enable(fetch_pc_enable),
    .mem_data_sel(mem_data_sel), .pc_sel(pc_sel), .save_data(save_data)
  );

  logic [28:0] obs_vec;
  assign obs_vec = {stack_sig, mem_wr, mem_rd, pop_pc1, pop_pc2, pop_ccr, flush, busy,
                    fetch_pc_enable, mem_data_sel, pc_sel, save_data};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which sequence is running (0 none, 1 interrupt, 2 RTI) and how far along.
  int          m_mode = 0;
  int          m_step = 0;
  logic [31:0] m_pc   = 32'h0;
  logic [2:0]  m_ccr  = 3'b0;

  int busy_cnt;
  int pcl_writes;

  function automatic logic [28:0] expected(input bit lu);
    logic s, w, r, p1, p2, pc_c, fl, bz, fe;
    logic [1:0]  ds, ps;
    logic [15:0] sd;
    s = 0; w = 0; r = 0; p1 = 0; p2 = 0; pc_c = 0; fl = 0; bz = 0; fe = 1;
    ds = 2'd0; ps = 2'd0; sd = 16'h0;
    if (m_mode != 0) begin
      fl = 1; bz = 1; fe = 0;
    end
    if (m_mode == 1) begin
      if (m_step < 3) begin
        s  = 1;
        w  = !lu;
        ds = 2'(m_step + 1);
      end else begin
        r  = !lu;
        ps = lu ? 2'd0 : 2'd2;
      end
    end else if (m_mode == 2) begin
      if (m_step < 3) begin
        s    = 1;
        r    = !lu;
        pc_c = (m_step == 0) && !lu;
        p2   = (m_step == 1) && !lu;
        p1   = (m_step == 2) && !lu;
      end else begin
        ps = lu ? 2'd0 : 2'd1;
      end
    end
    case (ds)
      2'd1:    sd = m_pc[31:16];
      2'd2:    sd = m_pc[15:0];
      2'd3:    sd = {13'b0, m_ccr};
      default: sd = 16'h0;
    endcase
    return {s, w, r, p1, p2, pc_c, fl, bz, fe, ds, ps, sd};
  endfunction

  task automatic model_clock(input bit r, input bit i, input bit t, input bit lu,
                             input logic [31:0] p, input logic [2:0] c);
    if (r) begin
      m_mode = 0; m_step = 0; m_pc = 32'h0; m_ccr = 3'b0;
    end else if (m_mode == 0) begin
      if (!lu) begin
        if (t) begin
          m_mode = 2; m_step = 0;
        end else if (i) begin
          m_mode = 1; m_step = 0; m_pc = p; m_ccr = c;
        end
      end
    end else if (!lu) begin
      m_step = m_step + 1;
      if (m_step == 4) begin
        m_mode = 0; m_step = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, then advance on the edge.
  task automatic cycle(input bit r, input bit i, input bit t, input bit lu,
                       input logic [31:0] p, input logic [2:0] c);
    rst = r; interrupt = i; rti = t; load_use = lu; pc = p; ccr = c;
    #1;
    chk("outputs", {3'b0, obs_vec}, {3'b0, expected(lu)});
    busy_cnt   += int'(busy);
    pcl_writes += int'(mem_wr && mem_data_sel == 2'b10);
    @(posedge clk);
    model_clock(r, i, t, lu, p, c);
    #1;
  endtask

  logic [2:0] exp_pops [4];
  logic [28:0] idle_vec;

  initial begin
    rst = 1; interrupt = 0; rti = 0; load_use = 0; pc = 32'h0; ccr = 3'b0;
    busy_cnt = 0; pcl_writes = 0;
    idle_vec = {9'b000000001, 2'b00, 2'b00, 16'h0000};
    exp_pops[0] = 3'b100; exp_pops[1] = 3'b010; exp_pops[2] = 3'b001; exp_pops[3] = 3'b000;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 32'h0, 3'b0);
    chk("reset_defaults", {3'b0, obs_vec}, {3'b0, idle_vec});

    // Interrupt entry: push PCH, PCL, CCR, then vector fetch.
    cycle(0, 1, 0, 0, 32'h0001_2345, 3'b101);
    chk("int_pch", {15'b0, mem_wr, save_data}, {15'b0, 1'b1, 16'h0001});
    cycle(0, 0, 0, 0, 32'h0, 3'b0);
    chk("int_pcl", {15'b0, mem_wr, save_data}, {15'b0, 1'b1, 16'h2345});
    cycle(0, 0, 0, 0, 32'h0, 3'b0);
    chk("int_ccr", {15'b0, mem_wr, save_data}, {15'b0, 1'b1, 16'h0005});
    cycle(0, 0, 0, 0, 32'h0, 3'b0);
    chk("int_vector", {29'b0, mem_rd, pc_sel}, {29'b0, 1'b1, 2'b10});
    cycle(0, 0, 0, 0, 32'h0, 3'b0);
    chk("int_done", {30'b0, busy, fetch_pc_enable}, {30'b0, 1'b0, 1'b1});

    // RTI: pops CCR, PCL, PCH, then resume; busy throughout.
    cycle(0, 0, 1, 0, 32'h0, 3'b0);
    for (int k = 0; k < 4; k++) begin
      chk("rti_step", {26'b0, busy, exp_pops[k] == 3'b000 ? pc_sel : 2'b00,
                       pop_ccr, pop_pc2, pop_pc1},
          {26'b0, 1'b1, k == 3 ? 2'b01 : 2'b00, exp_pops[k]});
      cycle(0, 0, 0, 0, 32'h0, 3'b0);
    end
    chk("rti_done", {31'b0, busy}, 32'h0);

    // RTI wins over a simultaneous interrupt; the interrupt is dropped.
    cycle(0, 1, 1, 0, 32'hDEAD_BEEF, 3'b111);
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 32'h0, 3'b0);
    chk("rti_priority_busy_cycles", busy_cnt, 4);

    // Stall for two cycles in PUSH_PCL: six busy cycles, exactly one PCL write.
    busy_cnt = 0; pcl_writes = 0;
    cycle(0, 1, 0, 0, 32'hCAFE_1234, 3'b010);
    cycle(0, 0, 0, 0, 32'h0, 3'b0);
    cycle(0, 0, 0, 1, 32'h0, 3'b0);
    cycle(0, 0, 0, 1, 32'h0, 3'b0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 32'h0, 3'b0);
    chk("stall_busy_cycles", busy_cnt, 6);
    chk("stall_pcl_writes", pcl_writes, 1);

    // Reset in the middle of an RTI sequence.
    cycle(0, 0, 1, 0, 32'h0, 3'b0);
    cycle(0, 0, 0, 0, 32'h0, 3'b0);
    cycle(1, 0, 0, 0, 32'h0, 3'b0);
    chk("reset_mid_rti", {3'b0, obs_vec}, {3'b0, idle_vec});

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(49) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
            ($urandom_range(4) == 0), $urandom, 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port interrupt, input, 1: external interrupt request, sampled each clk edge.
REQ-004 SHALL have port rti, input, 1: RTI decoded in ID this cycle.
REQ-005 SHALL have port load_use, input, 1: pipeline stall request.
REQ-006 SHALL have port pc, input, 32: return address (next instruction) at detection.
REQ-007 SHALL have port ccr, input, 3: current condition flags.
REQ-008 SHALL have outputs stack_sig, mem_wr, mem_rd, pop_pc1, pop_pc2, pop_ccr, flush, busy, each 1 bit; fetch_pc_enable, output, 1.
REQ-009 SHALL have outputs mem_data_sel, 2 bits (00 normal, 01 saved_pc[31:16], 10 saved_pc[15:0], 11 {13'b0, saved_ccr}), and pc_sel, 2 bits (00 sequential, 01 popped PC, 10 vector from memory).
REQ-010 SHALL have output save_data, 16 bits: stack write data selected by mem_data_sel.

Function
REQ-011 SHALL implement Moore FSM states IDLE, INT_PUSH_PCH, INT_PUSH_PCL, INT_PUSH_CCR, INT_VECTOR, RTI_POP_CCR, RTI_POP_PCL, RTI_POP_PCH, RTI_RESUME.
REQ-012 In IDLE, all outputs SHALL be defaults: strobes 0, selects 00, save_data 0, flush 0, busy 0, fetch_pc_enable 1.
REQ-013 IDLE with rti=1 and load_use=0 SHALL go to RTI_POP_CCR; rti has priority over interrupt in the same cycle.
REQ-014 IDLE with interrupt=1, rti=0 and load_use=0 SHALL capture pc into saved_pc and ccr into saved_ccr, then go to INT_PUSH_PCH.
REQ-015 Interrupt path SHALL run PCH -> PCL -> CCR -> VECTOR -> IDLE: 4 non-IDLE cycles.
REQ-016 Each INT_PUSH_* state SHALL assert stack_sig=1 and mem_wr=1, with mem_data_sel 01/10/11 respectively.
REQ-017 INT_VECTOR SHALL assert mem_rd=1, stack_sig=0 and pc_sel=10.
REQ-018 RTI path SHALL run POP_CCR -> POP_PCL -> POP_PCH -> RESUME -> IDLE, with stack_sig=1 and mem_rd=1 in each pop state.
REQ-019 RTI_POP_CCR SHALL assert pop_ccr; RTI_POP_PCL SHALL assert pop_pc2; RTI_POP_PCH SHALL assert pop_pc1; RTI_RESUME SHALL assert pc_sel=01.
REQ-020 In every non-IDLE state: busy=1, flush=1, fetch_pc_enable=0.
REQ-021 load_use=1 in a non-IDLE state SHALL hold the state and force mem_wr, mem_rd, pop_* to 0 and pc_sel to 00 that cycle; in IDLE it SHALL block both entries.
REQ-022 interrupt while busy, or while rti wins in IDLE, SHALL be handled per REQ-026/027.
REQ-023 saved_pc and saved_ccr SHALL change only on entry per REQ-014.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, clear saved_pc, saved_ccr and the pending flag, and give REQ-012 defaults next cycle, including mid-sequence.
REQ-025 rst SHALL take priority over every other input.

Configuration
REQ-026 With macro INT_PENDING_LATCH_EN defined, an interrupt not taken (busy, RTI priority, or load_use) SHALL set a pending flag. That flag SHALL be treated as interrupt=1 on the next eligible IDLE cycle and cleared on entry. Pending captures SHALL not stack: at most one.
REQ-027 Without INT_PENDING_LATCH_EN, an interrupt not taken SHALL be dropped, and no pending flag SHALL be built.

Verification
REQ-028 interrupt=1 for 1 cycle at T in IDLE, pc=0x0001_2345, ccr=3'b101 -> the following SHALL hold:
- T+1..T+3 mem_wr=1 with save_data 0x0001, 0x2345, 0x0005.
- T+4 mem_rd=1 and pc_sel=10.
- T+5 IDLE with fetch_pc_enable=1.
REQ-029 rti=1 in IDLE -> the following SHALL hold over four cycles, followed by IDLE:
- pop_ccr, then pop_pc2, then pop_pc1 in successive cycles.
- pc_sel=01 in RESUME.
- busy=1 throughout.
REQ-030 interrupt and rti both =1 in IDLE -> RTI sequence SHALL run. With INT_PENDING_LATCH_EN, INT_PUSH_PCH SHALL follow RTI_RESUME+IDLE; without, no interrupt sequence.
REQ-031 load_use=1 for 2 cycles during INT_PUSH_PCL -> state SHALL hold 2 extra cycles with mem_wr=0; the PCL write SHALL occur once afterward; total 6 non-IDLE cycles.
REQ-032 rst=1 during RTI_POP_PCL -> next cycle IDLE, all outputs default, saved_ccr=0.
